// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the 9-bit processor sequencer: FSM state encoding,
// the halt opcode, read-latency bounds, and Ctrl's existing opcode constants.
package proc_sequencer_pkg;

  typedef enum logic [2:0] {
    WAIT,
    ARMED,
    FETCH,
    EXEC,
    MEM,
    DONE
  } seq_state_t;

  localparam logic [8:0] kHALT = 9'h1FF;

  localparam int unsigned kMaxMemRdLat = 7;
  localparam int unsigned kMemCntW     = $clog2(kMaxMemRdLat + 1);

  // Ctrl opcode constants (consumed by Ctrl, not by the sequencer)
  localparam logic [2:0] kJ   = 3'b110;
  localparam logic [2:0] kBRE = 3'b111;

endpackage

// File: rtl/proc_sequencer_pc.sv
// Program counter register: START_PC preset, absolute load, or modulo-2^PC_W
// increment.
module seq_pc #(
  parameter int unsigned      PC_W     = 10,
  parameter logic [PC_W-1:0]  START_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            preset_i,
  input  logic            update_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (preset_i) begin
      pc_d = START_PC;
    end else if (update_i) begin
      // Natural overflow of the add provides the all-ones -> 0 wrap
      pc_d = jump_i ? target_i : pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= START_PC;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle run controller: owns PC/IR, Start/Ack handshake, and gates the
// decoder enables. Optional perf counters under `SEQ_PERF_CNT_EN`.
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int unsigned      PC_W       = 10,
  parameter logic [PC_W-1:0]  START_PC   = '0,
  parameter int unsigned      MEM_RD_LAT = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      inst_rom,
  input  logic            jump_en,
  input  logic            write_en,
  input  logic            ReadMem,
  input  logic            WriteMem,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] prog_ctr,
  output logic [8:0]      ir,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            Ack
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]     cycle_cnt,
  output logic [15:0]     instr_cnt
`endif
);

  seq_state_t          state_q, state_d;
  logic [8:0]          ir_q, ir_d;
  logic [kMemCntW-1:0] cnt_q, cnt_d;
  logic                abort;
  logic                pc_preset;
  logic                pc_update;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    reg_we    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    pc_preset = 1'b0;
    pc_update = 1'b0;
    abort     = Start && (state_q != WAIT) && (state_q != ARMED);

    // Abort overrides the whole case so no enable can leak out that cycle
    if (abort) begin
      state_d   = ARMED;
      pc_preset = 1'b1;
    end else begin
      unique case (state_q)
        WAIT: begin
          if (Start) begin
            state_d   = ARMED;
            pc_preset = 1'b1;
          end
        end
        ARMED: begin
          pc_preset = 1'b1;
          if (!Start) state_d = FETCH;
        end
        FETCH: begin
          ir_d    = inst_rom;
          state_d = EXEC;
        end
        EXEC: begin
          if (ir_q == kHALT) begin
            state_d = DONE;
          end else if (ReadMem) begin
            mem_re  = 1'b1;
            cnt_d   = kMemCntW'(MEM_RD_LAT);
            state_d = MEM;
          end else if (WriteMem) begin
            mem_we    = 1'b1;
            pc_update = 1'b1;
            state_d   = FETCH;
          end else begin
            reg_we    = write_en;
            pc_update = 1'b1;
            state_d   = FETCH;
          end
        end
        MEM: begin
          mem_re = 1'b1;
          if (cnt_q == kMemCntW'(1)) begin
            reg_we    = 1'b1;
            pc_update = 1'b1;
            state_d   = FETCH;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: ;
        default: state_d = WAIT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= WAIT;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  seq_pc #(
    .PC_W     (PC_W),
    .START_PC (START_PC)
  ) u_seq_pc (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .preset_i (pc_preset),
    .update_i (pc_update),
    .jump_i   (jump_en),
    .target_i (branch_target),
    .pc_o     (prog_ctr)
  );

  assign ir  = ir_q;
  assign Ack = (state_q == DONE);

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] ins_q, ins_d;

  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (state_d == ARMED && state_q != ARMED) begin
      cyc_d = '0;
      ins_d = '0;
    end else begin
      if ((state_q == FETCH || state_q == EXEC || state_q == MEM) && cyc_q != '1)
        cyc_d = cyc_q + 1'b1;
      if (state_q == EXEC && ir_q != kHALT && ins_q != '1)
        ins_d = ins_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`endif

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
- Multi-cycle run controller for the 9-bit basic processor.
- Owns the program counter and instruction register, and handles the Start/Ack handshake with the test harness.
- Gates the decoder's register-file and data-memory enables so each fires in exactly one defined cycle.
- Sits between InstROM and Ctrl: the IR feeds Ctrl, and Ctrl's flags come back in to be sequenced.

Parameters:
- PC_W, 10, program counter width.
- START_PC, 0, PC value loaded while Start is high.
- MEM_RD_LAT, 1, data-memory read latency in cycles (1..7).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  harness run request (level)
- inst_rom  in  9  InstROM output at address prog_ctr (combinational)
- jump_en  in  1  Ctrl: take branch/jump (already ZERO-qualified)
- write_en  in  1  Ctrl: instruction writes the register file
- ReadMem  in  1  Ctrl: load
- WriteMem  in  1  Ctrl: store
- branch_target  in  PC_W  absolute target from the jump LUT
- prog_ctr  out  PC_W  instruction address
- ir  out  9  latched instruction, drives Ctrl
- reg_we  out  1  gated register-file write enable
- mem_re  out  1  gated data-memory read enable
- mem_we  out  1  gated data-memory write enable
- Ack  out  1  program finished (halt reached)

Behaviour:
- All state is updated on posedge Clk.
- Reset has priority over everything. On Reset: state=WAIT, prog_ctr=START_PC, ir=0, reg_we=mem_re=mem_we=0, Ack=0, latency counter=0.
- Start=1 in any state except WAIT/ARMED aborts the run: next state=ARMED, prog_ctr=START_PC, Ack=0, and no enable fires that cycle.
- States:
  - WAIT: Start=1 -> ARMED; else stay.
  - ARMED: prog_ctr held at START_PC. Start=0 -> FETCH.
  - FETCH: ir <= inst_rom -> EXEC.
  - EXEC, ir==kHALT: -> DONE, Ack=1, prog_ctr unchanged, no enables.
  - EXEC, ReadMem=1: mem_re=1, counter=MEM_RD_LAT -> MEM.
  - EXEC, WriteMem=1: mem_we=1 for this cycle only; PC update -> FETCH.
  - EXEC, otherwise: reg_we=write_en; PC update -> FETCH.
  - MEM: mem_re held at 1; counter decrements. When counter==1: reg_we=1, PC update -> FETCH.
  - DONE: Ack=1 held until Start=1.
- PC update rule: jump_en ? branch_target : prog_ctr+1. The increment is modulo 2^PC_W, so the all-ones value wraps to 0.
- Enables are combinational from state plus Ctrl flags and are never asserted outside EXEC/MEM.
- At most one of reg_we/mem_we is high in any cycle. If both ReadMem and WriteMem are high, ReadMem wins.
- Latency: ALU/branch/store = 2 cycles/instr; load = 2+MEM_RD_LAT.
- kHALT is checked before the Ctrl flags, so a halt never writes.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[15:0] and instr_cnt[15:0].
  - Both clear on Reset and on entry to ARMED.
  - cycle_cnt increments every cycle in FETCH/EXEC/MEM.
  - instr_cnt increments on each EXEC exit, excluding halt.
  - Both saturate at 16'hFFFF and hold in DONE.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Add to package definitions:
  - state enum seq_state_t {WAIT, ARMED, FETCH, EXEC, MEM, DONE}
  - constant kHALT = 9'h1FF
  - localparam for the maximum MEM_RD_LAT
- Ctrl's opcode constants (kJ, kBRE) are already in the package and are not touched.
- One sub-module: seq_pc (PC register with load/increment/wrap, START_PC preset). The FSM stays in proc_sequencer.

Test Plan:
- Reset, Start 1 for 3 cycles then 0 -> prog_ctr=0 throughout, FETCH on the cycle after Start falls, ir=inst_rom[0] one cycle later.
- Non-memory instr with write_en=1, jump_en=0 at PC 5 -> reg_we high exactly 1 cycle (EXEC), prog_ctr=6 two cycles after FETCH.
- Load with MEM_RD_LAT=3 at PC 7 -> mem_re high 4 cycles, reg_we only in the last, prog_ctr=8 after 5 cycles, mem_we never high.
- jump_en=1, branch_target=10'h2A -> prog_ctr=10'h2A. PC_W=10 at prog_ctr=10'h3FF with jump_en=0 -> wraps to 0.
- ir=9'h1FF with write_en=1 -> no enable fires, Ack=1 and held, prog_ctr frozen. Start=1 -> Ack=0, prog_ctr=0.
- Reset asserted mid-MEM -> next cycle state=WAIT, all enables 0, Ack=0. Start=1 during EXEC of a store -> mem_we=0 that cycle, state ARMED.
